// File: rtl/dc_load_aligner_pkg.sv
// Shared types and the beat-alignment function for the data-cache load aligner.
// Metadata layout, size encodings and the byte/half/word/double extractor live here.
package dc_pkg;

    localparam int REQ_SIZE_LSB   = 0;
    localparam int REQ_SIGNED_BIT = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } dc_size_e;

    typedef struct packed {
        dc_size_e   size;
        logic       is_signed;
        logic [2:0] offset;
    } dc_meta_t;

    typedef struct packed {
        logic        misalign;
        logic [63:0] result;
    } dc_align_t;

    // A misaligned access returns the raw beat so the consumer can decide what to do.
    function automatic dc_align_t dc_align64(input logic [63:0] data, input dc_meta_t meta);
        dc_align_t   res;
        logic [63:0] sh;
        logic [2:0]  mask;
        case (meta.size)
            SZ_B:    mask = 3'd0;
            SZ_H:    mask = 3'd1;
            SZ_W:    mask = 3'd3;
            default: mask = 3'd7;
        endcase
        sh           = data >> {meta.offset, 3'b000};
        res.misalign = |(meta.offset & mask);
        if (res.misalign) begin
            res.result = data;
        end else begin
            case (meta.size)
                SZ_B:    res.result = {{56{meta.is_signed & sh[7]}},  sh[7:0]};
                SZ_H:    res.result = {{48{meta.is_signed & sh[15]}}, sh[15:0]};
                SZ_W:    res.result = {{32{meta.is_signed & sh[31]}}, sh[31:0]};
                default: res.result = sh;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/dc_load_aligner_chk.sv
// Protocol checker: a bank beat must never arrive while no metadata is queued.
// The enable input lets a bench exercise the error path deliberately.
module dc_load_aligner_chk #(
    parameter int META_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bank_valid,
    input  logic [$clog2(META_DEPTH):0]   meta_count,
    output logic                          proto_err
);

    localparam int CW = $clog2(META_DEPTH) + 1;

    assign proto_err = bank_valid & (meta_count == {CW{1'b0}});

    a_no_beat_when_empty: assert property (@(posedge clk) disable iff (reset || !enable) !proto_err);

endmodule

// File: rtl/dc_meta_fifo.sv
// Synchronous FIFO of load metadata with a combinational head (no read latency).
// Pushes while full and pops while empty are ignored.
module dc_meta_fifo
    import dc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  dc_meta_t                 push_data,
    input  logic                     pop,
    output dc_meta_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    dc_meta_t          mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/dc_load_aligner.sv
// Load aligner: pairs each in-order bank beat with its queued metadata, extracts and
// extends the addressed field, and holds the result in a single output register.
module dc_load_aligner
    import dc_pkg::*;
#(
    parameter int REQ_BITS   = 7,
    parameter int META_DEPTH = 4,
    parameter int DATA_W     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          meta_valid,
    output logic                          meta_retry,
    input  logic [REQ_BITS-1:0]           meta_type,
    input  logic [2:0]                    meta_offset,
    input  logic                          bank_valid,
    output logic                          bank_retry,
    input  logic [DATA_W-1:0]             bank_data,
    output logic                          ack_valid,
    input  logic                          ack_retry,
    output logic [DATA_W-1:0]             ack_data,
    output logic                          ack_misalign,
    output logic [$clog2(META_DEPTH):0]   meta_count
);

    dc_meta_t          push_meta_s;
    dc_meta_t          head_s;
    dc_align_t         align_s;
    logic              full_s;
    logic              empty_s;
    logic              push_acc_s;
    logic              beat_acc_s;
    logic              ack_valid_r;
    logic [DATA_W-1:0] ack_data_r;
    logic              ack_misalign_r;
    logic              unused_type_s;

    assign push_meta_s = '{size:      dc_size_e'(meta_type[REQ_SIZE_LSB +: 2]),
                           is_signed: meta_type[REQ_SIGNED_BIT],
                           offset:    meta_offset};
    assign unused_type_s = ^meta_type[REQ_BITS-1:3];

    assign meta_retry = full_s;
    assign push_acc_s = meta_valid & ~full_s;
    // A full output register still being stalled blocks the next beat.
    assign bank_retry = empty_s | (ack_valid_r & ack_retry);
    assign beat_acc_s = bank_valid & ~bank_retry;

    dc_meta_fifo #(
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_acc_s),
        .push_data (push_meta_s),
        .pop       (beat_acc_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (meta_count)
    );

    assign align_s = dc_align64(bank_data, head_s);

    // Output register: load on beat accept, drop once the consumer takes the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_valid_r    <= 1'b0;
            ack_data_r     <= {DATA_W{1'b0}};
            ack_misalign_r <= 1'b0;
        end else if (beat_acc_s) begin
            ack_valid_r    <= 1'b1;
            ack_data_r     <= align_s.result;
            ack_misalign_r <= align_s.misalign;
        end else if (ack_valid_r && !ack_retry) begin
            ack_valid_r    <= 1'b0;
            ack_data_r     <= ack_data_r;
            ack_misalign_r <= ack_misalign_r;
        end else begin
            ack_valid_r    <= ack_valid_r;
            ack_data_r     <= ack_data_r;
            ack_misalign_r <= ack_misalign_r;
        end
    end

    assign ack_valid    = ack_valid_r;
    assign ack_data     = ack_data_r;
    assign ack_misalign = ack_misalign_r;

endmodule

// File: tb/tb_dc_load_aligner.sv
// Directed bench for dc_load_aligner: hand-computed alignment results and handshake checks.
module tb_dc_load_aligner;

    logic        clk;
    logic        reset;
    logic        meta_valid;
    logic        meta_retry;
    logic [6:0]  meta_type;
    logic [2:0]  meta_offset;
    logic        bank_valid;
    logic        bank_retry;
    logic [63:0] bank_data;
    logic        ack_valid;
    logic        ack_retry;
    logic [63:0] ack_data;
    logic        ack_misalign;
    logic [2:0]  meta_count;
    logic        chk_enable;
    logic        proto_err;

    int tests = 0;
    int fails = 0;

    dc_load_aligner #(.REQ_BITS(7), .META_DEPTH(4), .DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .meta_valid   (meta_valid),
        .meta_retry   (meta_retry),
        .meta_type    (meta_type),
        .meta_offset  (meta_offset),
        .bank_valid   (bank_valid),
        .bank_retry   (bank_retry),
        .bank_data    (bank_data),
        .ack_valid    (ack_valid),
        .ack_retry    (ack_retry),
        .ack_data     (ack_data),
        .ack_misalign (ack_misalign),
        .meta_count   (meta_count)
    );

    dc_load_aligner_chk #(.META_DEPTH(4)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .enable     (chk_enable),
        .bank_valid (bank_valid),
        .meta_count (meta_count),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one metadata entry and wait (bounded) until it is accepted.
    task automatic push_meta(input logic [1:0] sz, input logic sg, input logic [2:0] off);
        int n;
        n = 0;
        meta_valid  = 1'b1;
        meta_type   = {4'hA, sg, sz};
        meta_offset = off;
        #1;
        while (meta_retry && n < 20) begin
            tick();
            n++;
        end
        chk("push_accept_bound", {63'd0, (n < 20)}, 64'd1);
        tick();
        meta_valid = 1'b0;
    endtask

    // Offer one beat (metadata already queued, consumer not stalling) and check the result.
    task automatic do_beat(input string tag, input logic [63:0] data,
                           input logic [63:0] exp_data, input logic exp_mis);
        bank_valid = 1'b1;
        bank_data  = data;
        #1;
        chk({tag, "_bank_retry"}, {63'd0, bank_retry}, 64'd0);
        tick();
        bank_valid = 1'b0;
        chk({tag, "_ack_valid"}, {63'd0, ack_valid}, 64'd1);
        chk({tag, "_ack_data"}, ack_data, exp_data);
        chk({tag, "_ack_misalign"}, {63'd0, ack_misalign}, {63'd0, exp_mis});
    endtask

    initial begin
        reset       = 1'b1;
        meta_valid  = 1'b0;
        meta_type   = 7'd0;
        meta_offset = 3'd0;
        bank_valid  = 1'b0;
        bank_data   = 64'd0;
        ack_retry   = 1'b0;
        chk_enable  = 1'b1;
        tick();
        tick();
        chk("rst_ack_valid", {63'd0, ack_valid}, 64'd0);
        chk("rst_ack_data", ack_data, 64'd0);
        chk("rst_ack_misalign", {63'd0, ack_misalign}, 64'd0);
        chk("rst_meta_count", {61'd0, meta_count}, 64'd0);
        chk("rst_meta_retry", {63'd0, meta_retry}, 64'd0);
        chk("rst_bank_retry", {63'd0, bank_retry}, 64'd1);
        reset = 1'b0;
        tick();

        // 1: word signed at offset 4; push into empty FIFO is not visible the same cycle
        meta_valid  = 1'b1;
        meta_type   = {4'hA, 1'b1, 2'd2};
        meta_offset = 3'd4;
        #1;
        chk("t1_no_bypass", {63'd0, bank_retry}, 64'd1);
        tick();
        meta_valid = 1'b0;
        chk("t1_count", {61'd0, meta_count}, 64'd1);
        chk("t1_ack_idle", {63'd0, ack_valid}, 64'd0);
        do_beat("t1", 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b0);
        chk("t1_count_after", {61'd0, meta_count}, 64'd0);
        tick();
        chk("t1_ack_clear", {63'd0, ack_valid}, 64'd0);

        // 2: byte at offset 7, unsigned then signed, back-to-back beats
        push_meta(2'd0, 1'b0, 3'd7);
        push_meta(2'd0, 1'b1, 3'd7);
        do_beat("t2u", 64'hA512_3456_789A_BCDE, 64'h0000_0000_0000_00A5, 1'b0);
        do_beat("t2s", 64'hA512_3456_789A_BCDE, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0);
        tick();

        // 3: misaligned half, half signed/unsigned, aligned double
        push_meta(2'd1, 1'b1, 3'd3);
        push_meta(2'd1, 1'b1, 3'd2);
        push_meta(2'd1, 1'b0, 3'd6);
        push_meta(2'd3, 1'b1, 3'd0);
        do_beat("t3_h_mis", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
        do_beat("t3_h_sgn", 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_89AB, 1'b0);
        do_beat("t3_h_uns", 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 1'b0);
        do_beat("t3_d", 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b0);
        tick();

        // 4: fill the FIFO, hold a 5th push, then pop alongside pushes
        push_meta(2'd3, 1'b0, 3'd0);
        push_meta(2'd0, 1'b0, 3'd0);
        push_meta(2'd0, 1'b0, 3'd1);
        push_meta(2'd0, 1'b0, 3'd2);
        chk("t4_full_count", {61'd0, meta_count}, 64'd4);
        chk("t4_meta_retry", {63'd0, meta_retry}, 64'd1);
        meta_valid  = 1'b1;
        meta_type   = {4'hA, 1'b0, 2'd0};
        meta_offset = 3'd3;
        tick();
        chk("t4_held_count", {61'd0, meta_count}, 64'd4);
        bank_valid = 1'b1;
        bank_data  = 64'h1122_3344_5566_7788;
        #1;
        chk("t4_retry_with_pop", {63'd0, meta_retry}, 64'd1);
        tick();
        chk("t4_pop_count", {61'd0, meta_count}, 64'd3);
        chk("t4_d_data", ack_data, 64'h1122_3344_5566_7788);
        chk("t4_push_open", {63'd0, meta_retry}, 64'd0);
        tick();
        meta_valid = 1'b0;
        bank_valid = 1'b0;
        chk("t4_pushpop_count", {61'd0, meta_count}, 64'd3);
        chk("t4_b0_data", ack_data, 64'h0000_0000_0000_0088);
        do_beat("t4_b1", 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0077, 1'b0);
        do_beat("t4_b2", 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0066, 1'b0);
        do_beat("t4_b3_held", 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0055, 1'b0);
        chk("t4_drained", {61'd0, meta_count}, 64'd0);
        tick();

        // 5: consumer stall holds the result and blocks the next beat
        push_meta(2'd2, 1'b0, 3'd0);
        push_meta(2'd2, 1'b0, 3'd4);
        do_beat("t5_first", 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_CAFE_F00D, 1'b0);
        ack_retry  = 1'b1;
        bank_valid = 1'b1;
        bank_data  = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_bank_retry", {63'd0, bank_retry}, 64'd1);
            chk("t5_stall_ack_valid", {63'd0, ack_valid}, 64'd1);
            chk("t5_stall_ack_data", ack_data, 64'h0000_0000_CAFE_F00D);
            tick();
        end
        chk("t5_stall_count", {61'd0, meta_count}, 64'd1);
        ack_retry = 1'b0;
        #1;
        chk("t5_release_bank_retry", {63'd0, bank_retry}, 64'd0);
        tick();
        bank_valid = 1'b0;
        chk("t5_second_valid", {63'd0, ack_valid}, 64'd1);
        chk("t5_second_data", ack_data, 64'h0000_0000_DEAD_BEEF);
        chk("t5_count", {61'd0, meta_count}, 64'd0);
        tick();
        chk("t5_ack_clear", {63'd0, ack_valid}, 64'd0);

        // 6: reset mid-operation, then a beat against an empty FIFO
        push_meta(2'd0, 1'b0, 3'd0);
        push_meta(2'd0, 1'b0, 3'd0);
        push_meta(2'd0, 1'b0, 3'd0);
        do_beat("t6_pre", 64'h0000_0000_0000_0042, 64'h0000_0000_0000_0042, 1'b0);
        chk("t6_pre_count", {61'd0, meta_count}, 64'd2);
        reset = 1'b1;
        tick();
        chk("t6_rst_ack_valid", {63'd0, ack_valid}, 64'd0);
        chk("t6_rst_ack_data", ack_data, 64'd0);
        chk("t6_rst_count", {61'd0, meta_count}, 64'd0);
        chk("t6_rst_bank_retry", {63'd0, bank_retry}, 64'd1);
        reset = 1'b0;
        tick();
        chk_enable = 1'b0;
        bank_valid = 1'b1;
        bank_data  = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("t6_empty_bank_retry", {63'd0, bank_retry}, 64'd1);
        chk("t6_proto_err", {63'd0, proto_err}, 64'd1);
        tick();
        chk("t6_empty_ack_valid", {63'd0, ack_valid}, 64'd0);
        chk("t6_empty_ack_data", ack_data, 64'd0);
        chk("t6_empty_count", {61'd0, meta_count}, 64'd0);
        bank_valid = 1'b0;
        chk_enable = 1'b1;
        tick();
        chk("t6_final_ack_valid", {63'd0, ack_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
